// File: rtl/dm_port_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port data memory between m0 (CPU) and m1 (loader).
// Latency: grant to rvalid is MEM_LAT+1 cycles, or 1 cycle for a misaligned/reserved-size request.
// Backpressure: requests wait with fields held until gnt; no grant while an access or response is in flight.
// Optional: define DM_ARB_LOG_EN to print every store as the merged post-write word.
module dm_port_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic              m0_err,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic              m1_err,
    output logic [31:0]       m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t            state;
    state_t            state_nx;
    logic              last;       // master served most recently
    logic              cur;        // master owning the current transaction
    logic              cap_we;
    logic [1:0]        cap_size;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic              cap_err;
    logic [2:0]        cnt;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;

    logic              pick;
    logic              grant;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_err;
    logic              last_cyc;
    logic [31:0]       shifted;
    logic [31:0]       load_val;

    // reserved size, or a half/word access not naturally aligned
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (sz)
            2'd1:    bad = lo[0];
            2'd2:    bad = 1'b1;
            2'd3:    bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // arbitration: on a tie the master not served last wins
    always_comb begin
        pick      = (m0_req && m1_req) ? ~last : m1_req;
        grant     = (state == IDLE) && (m0_req || m1_req) && !reset;
        sel_we    = pick ? m1_we    : m0_we;
        sel_size  = pick ? m1_size  : m0_size;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        sel_err   = misaligned(sel_size, sel_addr[1:0]);
        last_cyc  = (state == ACCESS) && (cnt == 3'd0);
    end

    // load data: right-justify the addressed lanes and zero the rest
    always_comb begin
        shifted  = mem_rdata >> {cap_addr[1:0], 3'b000};
        load_val = 32'd0;
        case (cap_size)
            2'd0:    load_val = {24'd0, shifted[7:0]};
            2'd1:    load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic; errored requests bypass the memory entirely
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = sel_err ? RESP : ACCESS;
            ACCESS:  if (cnt == 3'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // request capture, access countdown and per-master response data
    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            cur       <= 1'b0;
            cap_we    <= 1'b0;
            cap_size  <= 2'd0;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
            cap_err   <= 1'b0;
            cnt       <= 3'd0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            if (grant) begin
                last      <= pick;
                cur       <= pick;
                cap_we    <= sel_we;
                cap_size  <= sel_size;
                cap_addr  <= sel_addr;
                cap_wdata <= sel_wdata;
                cap_err   <= sel_err;
                cnt       <= LAT_M1;
                if (sel_err) begin
                    if (pick) rdata1_q <= 32'd0;
                    else      rdata0_q <= 32'd0;
                end
            end
            if ((state == ACCESS) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            if (last_cyc) begin
                if (cur) rdata1_q <= cap_we ? 32'd0 : load_val;
                else     rdata0_q <= cap_we ? 32'd0 : load_val;
            end
        end
    end

    // outputs: grant/response strobes and the memory-side drive during ACCESS
    always_comb begin
        m0_gnt    = grant && !pick;
        m1_gnt    = grant && pick;
        m0_rvalid = (state == RESP) && !cur;
        m1_rvalid = (state == RESP) && cur;
        m0_err    = m0_rvalid && cap_err;
        m1_err    = m1_rvalid && cap_err;
        m0_rdata  = rdata0_q;
        m1_rdata  = rdata1_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (state == ACCESS) begin
            mem_en   = 1'b1;
            mem_we   = cap_we;
            mem_addr = {cap_addr[ADDR_W-1:2], 2'b00};
            case (cap_size)
                2'd0: begin
                    mem_be    = 4'b0001 << cap_addr[1:0];
                    mem_wdata = {4{cap_wdata[7:0]}};
                end
                2'd1: begin
                    mem_be    = cap_addr[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{cap_wdata[15:0]}};
                end
                2'd3: begin
                    mem_be    = 4'b1111;
                    mem_wdata = cap_wdata;
                end
                default: begin
                    mem_be    = 4'b0000;
                    mem_wdata = 32'd0;
                end
            endcase
        end
    end

`ifdef DM_ARB_LOG_EN
    logic [31:0] merged;

    // word as it will read back after the store: old lanes kept where disabled
    always_comb begin
        merged = mem_rdata;
        for (int k = 0; k < 4; k++) begin
            if (mem_be[k]) merged[8*k +: 8] = mem_wdata[8*k +: 8];
        end
    end

    // store trace on the final access cycle
    always_ff @(posedge clk) begin
        if (!reset && last_cyc && cap_we) begin
            $display("%d@m%0d: *%h <= %h", $time, cur, mem_addr, merged);
        end
    end
`else
    // store trace disabled
`endif

endmodule
